pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic parametrised inter-stage pipeline register for the npc core, replacing the hand-written per-stage registers (id/ex, ex/mem, mem/wb).
- Carries one packed payload bus between stages with a valid/ready handshake, a stage-done gate (hold), and a synchronous flush.
- Optional 2-entry skid mode breaks the combinational ready path between stages.

Parameters:
- W, 64, payload width in bits; the caller packs pc, wb, mem and other fields into this bus.
- SKID, 0, 0 = single entry with combinational in_ready; 1 = main + skid entry with registered in_ready.
- RST_VAL, {W{1'b0}}, payload register value after reset.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- flush  input  1  kill all held entries; synchronous.
- hold  input  1  downstream-side work not done; blocks output transfer.
- in_valid  input  1  upstream has payload.
- in_ready  output  1  block can accept payload this cycle.
- in_data  input  W  upstream payload.
- out_valid  output  1  payload at out_data is valid and releasable.
- out_ready  input  1  downstream accepts.
- out_data  output  W  main-entry payload.
- occupancy  output  2  number of valid entries (0..1 when SKID=0, 0..2 when SKID=1).

Behaviour:
- State: main_v/main_d; when SKID=1 also skid_v/skid_d.
- Reset (sync): main_v = skid_v = 0; main_d = skid_d = RST_VAL. Resulting outputs: out_valid = 0, occupancy = 0, out_data = RST_VAL. in_ready is 1 during and after reset when flush = 0. Reset overrides flush and all transfers.
- out_valid = main_v & ~hold & ~flush.
- fire_out = out_valid & out_ready.
- fire_in = in_valid & in_ready.
- out_data = main_d at all times. It is undefined-but-stable when main_v = 0 and retains its last value, so no payload clear is needed.
- SKID=0:
  - in_ready = ~flush & (~main_v | fire_out). This is a combinational path from out_ready and hold.
  - On fire_in: main_d <= in_data, main_v <= 1.
  - Else on fire_out: main_v <= 0.
  - Latency in->out: 1 cycle. Full throughput when out_ready = 1 and hold = 0.
- SKID=1:
  - in_ready = ~skid_v & ~flush. Depends only on registers plus flush.
  - Transition priority per edge:
    - fire_out & skid_v: main_d <= skid_d, skid_v <= 0. No fire_in is possible this cycle.
    - fire_in & (~main_v | fire_out): main_d <= in_data, main_v <= 1.
    - fire_in & main_v & ~fire_out: skid_d <= in_data, skid_v <= 1.
    - fire_out & ~fire_in & ~skid_v: main_v <= 0.
  - Order preservation: skid never holds data while main is empty. Invariant: skid_v implies main_v.
  - Latency 1 cycle; sustains 1 transfer/cycle.
- Flush:
  - While flush = 1: out_valid = 0, in_ready = 0.
  - At the edge: main_v <= 0, skid_v <= 0; payload registers unchanged.
  - Any in_valid presented during flush is dropped and not accepted.
- hold = 1 with main_v = 1: out_valid = 0 and data is retained.
  - SKID=0: in_ready = 0.
  - SKID=1: one more beat is absorbed into skid, then in_ready = 0.
- occupancy = main_v + skid_v. skid_v is tied to 0 when SKID=0.
- out_ready may be asserted with out_valid = 0; this has no effect.

Test Plan:
- Reset/flow (SKID=0 and SKID=1): assert reset for 2 cycles with in_valid = 1 -> out_valid = 0, occupancy = 0, out_data = RST_VAL. Then stream 0x11, 0x22, 0x33 with out_ready = 1, hold = 0 -> each appears on out_data exactly 1 cycle after acceptance, no bubbles.
- Backpressure, SKID=1: stream 0xA0..0xA3 with out_ready = 0 -> 0xA0 in main, 0xA1 in skid, in_ready = 0 from cycle 2, occupancy = 2. Then release out_ready -> outputs 0xA0, 0xA1, 0xA2, 0xA3 in order, no loss or duplication.
- hold gating: main holds 0x55, hold = 1 for 3 cycles, out_ready = 1 -> out_valid = 0 throughout, out_data = 0x55. Drop hold -> one transfer of 0x55.
- Flush with full skid (SKID=1, occupancy = 2): assert flush with in_valid = 1, in_data = 0x77 -> in_ready = 0 and out_valid = 0 that cycle. Next cycle occupancy = 0 and 0x77 is never output.
- Combinational ready, SKID=0: main_v = 1, out_ready toggles 0/1 each cycle -> in_ready follows out_ready in the same cycle. Toggling hold -> in_ready = 0 whenever hold = 1.
- Reset mid-stream with occupancy = 2 and flush = 1 simultaneously -> reset wins; occupancy = 0 next cycle, out_data = RST_VAL.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake, hold gate,
// synchronous flush and an optional second (skid) entry that registers in_ready.
module pipe_stage_reg #(
  parameter int unsigned   W       = 64,
  parameter int unsigned   SKID    = 0,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         hold,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  localparam int unsigned OCC_W = 2;

  logic         r_main_v;
  logic [W-1:0] r_main_d;
  logic         r_skid_v;
  logic [W-1:0] r_skid_d;

  logic w_out_valid;
  logic w_fire_out;
  logic w_in_ready;
  logic w_fire_in;

  // Handshake qualifiers; skid mode keeps in_ready off the downstream ready path.
  always_comb begin
    w_out_valid = r_main_v & ~hold & ~flush;
    w_fire_out  = w_out_valid & out_ready;
    if (SKID != 0) begin
      w_in_ready = ~r_skid_v & ~flush;
    end else begin
      w_in_ready = ~flush & (~r_main_v | w_fire_out);
    end
    w_fire_in = in_valid & w_in_ready;
  end

  // Entry state; payload registers are left untouched by flush and drain.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_main_v <= 1'b0;
      r_main_d <= RST_VAL;
      r_skid_v <= 1'b0;
      r_skid_d <= RST_VAL;
    end else if (flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (SKID != 0) begin
      if (w_fire_out && r_skid_v) begin
        r_main_d <= r_skid_d;
        r_skid_v <= 1'b0;
      end else if (w_fire_in && (!r_main_v || w_fire_out)) begin
        r_main_d <= in_data;
        r_main_v <= 1'b1;
      end else if (w_fire_in) begin
        r_skid_d <= in_data;
        r_skid_v <= 1'b1;
      end else if (w_fire_out) begin
        r_main_v <= 1'b0;
      end
    end else begin
      if (w_fire_in) begin
        r_main_d <= in_data;
        r_main_v <= 1'b1;
      end else if (w_fire_out) begin
        r_main_v <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main_d;
  assign occupancy = OCC_W'(r_main_v) + OCC_W'(r_skid_v);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one single-entry and one skid instance on a shared clock.
module tb_pipe_stage_reg;

  localparam int unsigned W = 16;
  localparam logic [W-1:0] RV = 16'hBEEF;

  logic clock = 1'b0;
  logic reset;

  logic         a_flush, a_hold, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [W-1:0] a_in_data, a_out_data;
  logic [1:0]   a_occ;
  logic         b_flush, b_hold, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [W-1:0] b_in_data, b_out_data;
  logic [1:0]   b_occ;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clock = ~clock;

  pipe_stage_reg #(.W(W), .SKID(0), .RST_VAL(RV)) u_a (
    .clock(clock), .reset(reset), .flush(a_flush), .hold(a_hold),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_stage_reg #(.W(W), .SKID(1), .RST_VAL(RV)) u_b (
    .clock(clock), .reset(reset), .flush(b_flush), .hold(b_hold),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [W-1:0] v [0:2];
    v[0] = 16'h0011; v[1] = 16'h0022; v[2] = 16'h0033;

    // Reset for two cycles with traffic presented
    reset = 1'b1;
    a_flush = 1'b0; a_hold = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h0099; a_out_ready = 1'b1;
    b_flush = 1'b0; b_hold = 1'b0; b_in_valid = 1'b1; b_in_data = 16'h0099; b_out_ready = 1'b1;
    step(); step();
    settle();
    chk("a_rst_valid", 32'(a_out_valid), 32'd0);
    chk("a_rst_occ",   32'(a_occ),       32'd0);
    chk("a_rst_data",  32'(a_out_data),  32'(RV));
    chk("a_rst_ready", 32'(a_in_ready),  32'd1);
    chk("b_rst_valid", 32'(b_out_valid), 32'd0);
    chk("b_rst_occ",   32'(b_occ),       32'd0);
    chk("b_rst_data",  32'(b_out_data),  32'(RV));
    chk("b_rst_ready", 32'(b_in_ready),  32'd1);
    step();

    // Stream 0x11, 0x22, 0x33 at full rate
    reset = 1'b0;
    a_in_data = v[0]; b_in_data = v[0];
    settle();
    chk("a_flow_rdy0", 32'(a_in_ready), 32'd1);
    chk("b_flow_rdy0", 32'(b_in_ready), 32'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        a_in_data = v[i+1]; b_in_data = v[i+1];
      end else begin
        a_in_valid = 1'b0; b_in_valid = 1'b0;
      end
      settle();
      chk("a_flow_valid", 32'(a_out_valid), 32'd1);
      chk("a_flow_data",  32'(a_out_data),  32'(v[i]));
      chk("b_flow_valid", 32'(b_out_valid), 32'd1);
      chk("b_flow_data",  32'(b_out_data),  32'(v[i]));
      chk("a_flow_ready", 32'(a_in_ready),  32'd1);
      chk("b_flow_ready", 32'(b_in_ready),  32'd1);
      step();
    end
    settle();
    chk("a_flow_empty", 32'(a_out_valid), 32'd0);
    chk("b_flow_empty", 32'(b_occ),       32'd0);

    // hold gating on 0x55
    a_in_valid = 1'b1; a_in_data = 16'h0055;
    b_in_valid = 1'b1; b_in_data = 16'h0055;
    step();
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_hold = 1'b1; b_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("a_hold_valid", 32'(a_out_valid), 32'd0);
      chk("a_hold_data",  32'(a_out_data),  32'h55);
      chk("a_hold_ready", 32'(a_in_ready),  32'd0);
      chk("b_hold_valid", 32'(b_out_valid), 32'd0);
      chk("b_hold_data",  32'(b_out_data),  32'h55);
      chk("b_hold_ready", 32'(b_in_ready),  32'd1);
      step();
    end
    a_hold = 1'b0; b_hold = 1'b0;
    settle();
    chk("a_hold_rel", 32'(a_out_valid), 32'd1);
    chk("b_hold_rel", 32'(b_out_valid), 32'd1);
    step();
    settle();
    chk("a_hold_once", 32'(a_out_valid), 32'd0);
    chk("b_hold_once", 32'(b_occ),       32'd0);

    // Backpressure into skid: A0..A3 with out_ready low
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 16'h00A0;
    step();
    b_in_data = 16'h00A1;
    settle();
    chk("b_bp_rdy1", 32'(b_in_ready), 32'd1);
    step();
    b_in_data = 16'h00A2;
    settle();
    chk("b_bp_rdy2", 32'(b_in_ready),  32'd0);
    chk("b_bp_occ2", 32'(b_occ),       32'd2);
    chk("b_bp_main", 32'(b_out_data),  32'hA0);
    step();
    settle();
    chk("b_bp_stall", 32'(b_occ), 32'd2);
    b_out_ready = 1'b1;
    chk("b_bp_out0", 32'(b_out_data), 32'hA0);
    step();
    b_in_data = 16'h00A2;
    settle();
    chk("b_bp_out1", 32'(b_out_data), 32'hA1);
    chk("b_bp_v1",   32'(b_out_valid), 32'd1);
    step();
    b_in_data = 16'h00A3;
    settle();
    chk("b_bp_out2", 32'(b_out_data), 32'hA2);
    step();
    b_in_valid = 1'b0;
    settle();
    chk("b_bp_out3", 32'(b_out_data), 32'hA3);
    chk("b_bp_v3",   32'(b_out_valid), 32'd1);
    step();
    settle();
    chk("b_bp_done", 32'(b_occ), 32'd0);

    // Flush with a full skid while 0x77 is offered
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 16'h00B0;
    step();
    b_in_data = 16'h00B1;
    step();
    settle();
    chk("b_fl_occ2", 32'(b_occ), 32'd2);
    b_flush = 1'b1; b_in_data = 16'h0077;
    #1;
    chk("b_fl_ready", 32'(b_in_ready),  32'd0);
    chk("b_fl_valid", 32'(b_out_valid), 32'd0);
    step();
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    settle();
    chk("b_fl_occ0", 32'(b_occ),       32'd0);
    chk("b_fl_data", 32'(b_out_data),  32'hB0);
    step();
    settle();
    chk("b_fl_no77", 32'(b_out_valid), 32'd0);

    // Combinational in_ready follows out_ready, then hold
    a_in_valid = 1'b1; a_in_data = 16'h0066; a_out_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      a_out_ready = (i % 2 == 1);
      settle();
      chk("a_cr_oready", 32'(a_in_ready), 32'(i % 2));
      step();
    end
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_hold = (i % 2 == 1);
      settle();
      chk("a_cr_hold", 32'(a_in_ready), 32'((i + 1) % 2));
      step();
    end
    a_hold = 1'b0; a_in_valid = 1'b0;
    step(); step();

    // Reset and flush together mid-stream
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'h00C0;
    b_in_valid = 1'b1; b_in_data = 16'h00C0;
    step();
    b_in_data = 16'h00C1;
    step();
    settle();
    chk("b_rm_occ2", 32'(b_occ), 32'd2);
    chk("a_rm_occ1", 32'(a_occ), 32'd1);
    reset = 1'b1; b_flush = 1'b1; b_in_data = 16'h0088;
    step();
    reset = 1'b0; b_flush = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
    settle();
    chk("b_rm_occ0", 32'(b_occ),      32'd0);
    chk("b_rm_data", 32'(b_out_data), 32'(RV));
    chk("a_rm_occ0", 32'(a_occ),      32'd0);
    chk("a_rm_data", 32'(a_out_data), 32'(RV));
    b_out_ready = 1'b1;
    step();
    settle();
    chk("b_rm_valid", 32'(b_out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
